// File: rtl/ysyx_25040105_ifu_axil.sv
// Multi-cycle instruction fetch unit: one AXI4-Lite read per instruction, valid/ready hand-off to the IDU.
// Optional performance counters are enabled by defining YSYX_25040105_IFU_PERF_EN.
module ysyx_25040105_ifu_axil #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // AXI4-Lite read channels
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // Instruction hand-off toward the IDU
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  // Next-PC return path from execute/write-back
  input  logic        wb_valid,
  input  logic [31:0] wb_next_pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cyc,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a valid, once raised, holds with its payload stable until that edge.
  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_fault;
  logic        w_r_hs;
  logic        w_wb_take;
  logic        w_wb_misaligned;

  assign w_r_hs          = (r_state == S_R) && rvalid;
  assign w_wb_take       = (r_state == S_WAIT) && wb_valid;
  assign w_wb_misaligned = (wb_next_pc[1:0] != 2'b00);

  // Handshake outputs depend only on r_state, never combinationally on an input.
  always_comb begin
    w_next_state = r_state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_AR: begin
        arvalid = 1'b1;
        if (arready) w_next_state = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) w_next_state = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (wb_valid) w_next_state = w_wb_misaligned ? S_OUT : S_AR;
      end
      default: w_next_state = S_AR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_AR;
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_r_hs) begin
        r_inst  <= rdata;
        r_fault <= (rresp != 2'b00);
      end
      if (w_wb_take) begin
        r_pc <= wb_next_pc;
        // A misaligned target is reported as a fault without touching the bus.
        if (w_wb_misaligned) begin
          r_inst  <= 32'h0;
          r_fault <= 1'b1;
        end
      end
    end
  end

  assign araddr    = r_pc;
  assign out_pc    = r_pc;
  assign out_inst  = r_inst;
  assign out_fault = r_fault;
  assign dbg_state = r_state;

`ifdef YSYX_25040105_IFU_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cyc <= 32'h0;
    end else begin
      if (w_r_hs) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == S_AR) || (r_state == S_R)) r_stall_cyc <= r_stall_cyc + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cyc = r_stall_cyc;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cyc = 32'h0;
`endif

endmodule

// File: doc/ysyx_25040105_ifu_axil.md
# ysyx_25040105_ifu_axil

Multi-cycle instruction fetch unit that replaces the single-cycle PC/instruction path feeding the decoder. It holds the PC, issues one AXI4-Lite read per instruction, and presents the fetched word to the IDU over a valid/ready handshake. It then waits for the execute/write-back stage to return the next PC before fetching again. Exactly one instruction is in flight at any time.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset; must be 4-byte aligned.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- araddr  out  32  AXI-Lite read address; equals current PC.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  32  read data.
- rresp  in  2  read response; 2'b00 = OKAY, anything else = error.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- out_valid  out  1  fetched instruction valid toward IDU.
- out_ready  in  1  IDU accepts instruction.
- out_pc  out  32  PC of presented instruction.
- out_inst  out  32  presented instruction word.
- out_fault  out  1  fetch fault: bus error or misaligned PC.
- wb_valid  in  1  next-PC update from execute/write-back.
- wb_next_pc  in  32  next PC to fetch.
- perf_fetch_cnt  out  32  completed fetches (see Configuration).
- perf_stall_cyc  out  32  cycles spent in S_AR/S_R (see Configuration).

## Operation
- States: S_AR, S_R, S_OUT, S_WAIT. Reset state S_AR, pc = RESET_PC.
- S_AR: arvalid = 1, araddr = pc. On arvalid && arready -> S_R.
- S_R: rready = 1. On rvalid: latch rdata into out_inst, set out_fault = (rresp != 2'b00), -> S_OUT.
- S_OUT: out_valid = 1; out_pc, out_inst, out_fault held stable. On out_ready -> S_WAIT.
- S_WAIT: all handshake outputs 0. On wb_valid: pc <= wb_next_pc.
  - If wb_next_pc[1:0] == 0 -> S_AR.
  - If misaligned -> S_OUT directly with out_fault = 1 and out_inst = 32'h0; no bus transaction is issued.
- wb_valid is ignored in every state other than S_WAIT.
- A faulted instruction is still handed over and still requires out_ready. Fault handling (trap or halt) belongs downstream.
- arvalid, once asserted, stays asserted with araddr stable until arready (AXI rule). No address is withdrawn.
- rready is asserted only in S_R. rvalid outside S_R is a slave protocol error with undefined behaviour; the bench flags it.

## Timing
- Reset values: arvalid = 0, rready = 0, out_valid = 0, out_fault = 0, out_inst = 0, out_pc = RESET_PC, perf counters = 0.
- The first cycle after rst deasserts has arvalid = 1 and araddr = RESET_PC.
- arvalid, rready and out_valid are decoded from registered state only, with no combinational path from any input.
- Minimum fetch latency with a zero-wait slave (arready = 1; rvalid in the cycle after the AR handshake): AR handshake in cycle N, R handshake in N+1, out_valid in N+2.
- out_valid and out_ready in the same cycle: transfer completes, and out_valid = 0 the next cycle.
- wb_valid in the cycle S_WAIT is entered is accepted. The fetch restarts with arvalid = 1 the following cycle.
- rst asserted in any state, including mid-AR or mid-R: the next cycle is S_AR with reset values. The bus slave is reset by the same rst, so no stale response is expected.
- PC arithmetic: 32-bit, no carry out. The IFU never increments the PC itself; wb_next_pc is authoritative, and wrap from 32'hFFFF_FFFC to 0 is legal.

## Configuration
- Macro YSYX_25040105_IFU_PERF_EN.
- Defined:
  - perf_fetch_cnt increments on each R handshake.
  - perf_stall_cyc increments every cycle the state is S_AR or S_R.
  - Both are 32-bit, wrap silently, and are cleared by rst.
- Undefined: both ports are tied to 32'h0 and no counter flops are synthesized. The port list is identical in both builds.

## Test plan
- Reset release, zero-wait slave returning 32'h00000413 at 32'h8000_0000: arvalid in cycle 1, out_valid in cycle 3 with out_pc = 32'h8000_0000, out_inst = 32'h00000413, out_fault = 0.
- Slave holds arready = 0 for 5 cycles and delays rvalid 3 cycles: araddr stable throughout, exactly one AR and one R handshake. With PERF_EN, perf_stall_cyc = 10 and perf_fetch_cnt = 1.
- out_ready held low for 4 cycles: out_valid, out_pc and out_inst stay constant. No new AR is issued before wb_valid.
- rresp = 2'b10: out_fault = 1 with out_inst = rdata. After wb_valid with 32'h8000_0004, the next fetch has araddr = 32'h8000_0004.
- wb_next_pc = 32'h8000_0006: arvalid never asserts; out_valid = 1 with out_fault = 1, out_inst = 0, out_pc = 32'h8000_0006.
- rst pulsed for one cycle while in S_R: the next cycle has arvalid = 1, araddr = RESET_PC, out_valid = 0, and counters = 0.
